cadd_arbiter: RTL and testbench
===============================

CADD_ARBITER -- requirements
Module: cadd_arbiter

Interface
REQ-001 SHALL have parameter WL, default 14, meaning operand word length (signed, two's complement).
REQ-002 SHALL have parameter WL_out, default 15, meaning result word length; legal range WL+1 or more.
REQ-003 SHALL have parameter NREQ, default 4, meaning number of requesters; legal range 2 to 8.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset, sampled on rising clk.
REQ-006 SHALL have port req_valid, input, NREQ bits: requester i holds an operand pair.
REQ-007 SHALL have port req_ready, output, NREQ bits: requester i's pair is accepted this cycle.
REQ-008 SHALL have ports req_ar, req_ai, req_br, req_bi, input, NREQ*WL bits each: packed operands, slice i at bits [i*WL +: WL].
REQ-009 SHALL have port out_valid, output, 1 bit: result register holds a valid result.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream consumer accepts the result.
REQ-011 SHALL have ports out_cr and out_ci, output, WL_out bits each: signed real and imaginary sums.
REQ-012 SHALL have port out_id, output, clog2(NREQ) bits: index of the requester that produced the result.

Function
REQ-013 SHALL time-share one complex adder: cr = ar+br, ci = ai+bi, operands sign-extended to WL_out before the add; no overflow possible.
REQ-014 SHALL define stage-free as (!out_valid || out_ready); a grant is issued only while stage-free is 1.
REQ-015 SHALL assert at most one req_ready bit per cycle (one-hot or zero); req_ready[i] SHALL be 1 only when req_valid[i] is 1 and stage-free is 1.
REQ-016 SHALL drive req_ready combinationally from req_valid, arbiter state and stage-free, with no combinational path from req_a*/req_b* data.
REQ-017 SHALL register the sum, out_id and out_valid=1 on the edge where req_ready[i] && req_valid[i]: latency is exactly 1 cycle from acceptance to out_valid.
REQ-018 SHALL hold out_cr, out_ci and out_id stable while out_valid && !out_ready.
REQ-019 SHALL clear out_valid on out_valid && out_ready when there is no new grant in the same cycle; a simultaneous grant SHALL reload the register with out_valid kept at 1, giving full throughput of 1 result per cycle.
REQ-020 SHALL implement arbiter states IDLE (no output held) and BUSY (out_valid=1): IDLE->BUSY on grant; BUSY->BUSY on stall or on pop with grant; BUSY->IDLE on pop without grant.
REQ-021 SHALL keep pointer last_id (the last granted index); it updates only on an actual grant.
REQ-022 SHALL ignore req_valid changes while stage-free is 0; requesters SHALL see req_ready=0 for all bits.

Reset
REQ-023 SHALL, on rst_n=0 at a clk edge, set out_valid=0, out_cr=0, out_ci=0, out_id=0, last_id=NREQ-1 and state=IDLE.
REQ-024 SHALL drive req_ready all 0 during any cycle where rst_n=0.
REQ-025 SHALL discard a held result if reset is asserted mid-operation; no result SHALL be emitted for it after reset.

Configuration
REQ-026 SHALL recognise macro CADD_RR_EN. When it is defined, arbitration SHALL be round-robin: the grant goes to the first valid index after last_id, modulo NREQ. When it is not defined, arbitration SHALL be fixed priority with the lowest valid index winning, and last_id SHALL be unused.

Structure
REQ-027 SHALL place the default WL, WL_out and NREQ constants, the state enum (IDLE, BUSY) and the id-width function in the shared package cadd_pkg.
REQ-028 SHALL contain exactly one sub-module, cadd_rr_pick: combinational, taking req_valid, last_id and the mode, and returning a one-hot grant plus an index.

Verification
REQ-029 SHALL cover: reset, then req_valid=4'b0001 with ar=100, ai=-5, br=27, bi=-8 and out_ready=1 -> next cycle out_valid=1, cr=127, ci=-13, out_id=0.
REQ-030 SHALL cover extremes with WL=14: ar=br=-8192 and ai=ai_b=8191 -> cr=-16384 and ci=16382 exactly, with no wrap.
REQ-031 SHALL cover CADD_RR_EN defined, all 4 valid, out_ready=1 for 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 with one result per cycle.
REQ-032 SHALL cover CADD_RR_EN undefined, req_valid=4'b1010 held -> every grant goes to index 1; index 3 is never granted.
REQ-033 SHALL cover out_ready=0 for 5 cycles with requests pending -> out_* is stable, req_ready=0 throughout; out_ready=1 then gives pop and reload in the same cycle.
REQ-034 SHALL cover rst_n=0 asserted while out_valid=1 and stalled -> next cycle out_valid=0, out_id=0, and round-robin restarts at index 0.

Source files
------------

// File: rtl/cadd_pkg.sv
// Shared constants, arbiter state type and id-width helper for the
// time-shared complex adder arbiter.
package cadd_pkg;

   localparam int DEF_WL     = 14;
   localparam int DEF_WL_OUT = 15;
   localparam int DEF_NREQ   = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } cadd_state_e;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cadd_rr_pick.sv
// Combinational grant picker: fixed lowest-index priority, or round-robin
// starting just after last_id when rr_mode is set.
module cadd_rr_pick
   import cadd_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = id_width(DEF_NREQ)
) (
   input  logic [NREQ-1:0] req_valid,
   input  logic [IDW-1:0]  last_id,
   input  logic            rr_mode,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx
);

   int   cand_s;
   logic found_s;

   // Scan candidates in priority order and take the first valid one.
   always_comb begin
      grant   = '0;
      idx     = '0;
      found_s = 1'b0;
      cand_s  = 0;
      for (int k = 0; k < NREQ; k++) begin
         if (rr_mode) begin
            cand_s = (int'(last_id) + k + 1) % NREQ;
         end else begin
            cand_s = k;
         end
         if (!found_s && req_valid[cand_s]) begin
            found_s       = 1'b1;
            grant[cand_s] = 1'b1;
            idx           = cand_s[IDW-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

endmodule

// File: rtl/cadd_arbiter.sv
// Arbiter sharing one complex adder among NREQ requesters with a single
// output register. Define CADD_RR_EN for round-robin; default is fixed priority.
module cadd_arbiter
   import cadd_pkg::*;
#(
   parameter int WL     = DEF_WL,
   parameter int WL_out = DEF_WL_OUT,
   parameter int NREQ   = DEF_NREQ,
   localparam int IDW   = id_width(NREQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [NREQ-1:0]  req_valid,
   output logic [NREQ-1:0]  req_ready,
   input  logic [NREQ*WL-1:0] req_ar,
   input  logic [NREQ*WL-1:0] req_ai,
   input  logic [NREQ*WL-1:0] req_br,
   input  logic [NREQ*WL-1:0] req_bi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WL_out-1:0] out_cr,
   output logic [WL_out-1:0] out_ci,
   output logic [IDW-1:0]   out_id
);

`ifdef CADD_RR_EN
   localparam logic RR_MODE = 1'b1;
`else
   localparam logic RR_MODE = 1'b0;
`endif

   cadd_state_e        state_r;
   logic               out_valid_r;
   logic [WL_out-1:0]  out_cr_r;
   logic [WL_out-1:0]  out_ci_r;
   logic [IDW-1:0]     out_id_r;
   logic [IDW-1:0]     last_id_r;

   logic               stage_free_s;
   logic [NREQ-1:0]    pick_grant_s;
   logic [IDW-1:0]     pick_idx_s;
   logic               grant_any_s;
   logic [WL-1:0]      sel_ar_s, sel_ai_s, sel_br_s, sel_bi_s;
   logic [WL_out-1:0]  sum_cr_s, sum_ci_s;

   cadd_rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .req_valid (req_valid),
      .last_id   (last_id_r),
      .rr_mode   (RR_MODE),
      .grant     (pick_grant_s),
      .idx       (pick_idx_s)
   );

   assign stage_free_s = (state_r == IDLE) || out_ready;
   assign req_ready    = (rst_n && stage_free_s) ? pick_grant_s : {NREQ{1'b0}};
   assign grant_any_s  = |req_ready;

   // Operand mux is steered only by the picked index, never back into req_ready.
   assign sel_ar_s = req_ar[int'(pick_idx_s)*WL +: WL];
   assign sel_ai_s = req_ai[int'(pick_idx_s)*WL +: WL];
   assign sel_br_s = req_br[int'(pick_idx_s)*WL +: WL];
   assign sel_bi_s = req_bi[int'(pick_idx_s)*WL +: WL];

   assign sum_cr_s = {{(WL_out-WL){sel_ar_s[WL-1]}}, sel_ar_s}
                   + {{(WL_out-WL){sel_br_s[WL-1]}}, sel_br_s};
   assign sum_ci_s = {{(WL_out-WL){sel_ai_s[WL-1]}}, sel_ai_s}
                   + {{(WL_out-WL){sel_bi_s[WL-1]}}, sel_bi_s};

   // Arbiter FSM plus result register; a grant always reloads, pop alone empties.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         out_valid_r <= 1'b0;
         out_cr_r    <= '0;
         out_ci_r    <= '0;
         out_id_r    <= '0;
         last_id_r   <= IDW'(NREQ - 1);
      end else begin
         case (state_r)
            IDLE: begin
               if (grant_any_s) begin
                  state_r     <= BUSY;
                  out_valid_r <= 1'b1;
                  out_cr_r    <= sum_cr_s;
                  out_ci_r    <= sum_ci_s;
                  out_id_r    <= pick_idx_s;
`ifdef CADD_RR_EN
                  last_id_r   <= pick_idx_s;
`endif
               end else begin
                  state_r     <= IDLE;
               end
            end
            BUSY: begin
               if (grant_any_s) begin
                  state_r     <= BUSY;
                  out_valid_r <= 1'b1;
                  out_cr_r    <= sum_cr_s;
                  out_ci_r    <= sum_ci_s;
                  out_id_r    <= pick_idx_s;
`ifdef CADD_RR_EN
                  last_id_r   <= pick_idx_s;
`endif
               end else if (out_ready) begin
                  state_r     <= IDLE;
                  out_valid_r <= 1'b0;
               end else begin
                  state_r     <= BUSY;
               end
            end
            default: begin
               state_r     <= IDLE;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_r;
   assign out_cr    = out_cr_r;
   assign out_ci    = out_ci_r;
   assign out_id    = out_id_r;

endmodule

// File: tb/tb_cadd_arbiter.sv
// Directed bench for cadd_arbiter; expectations follow the CADD_RR_EN setting.
module tb_cadd_arbiter;

   localparam int WL = 14;
   localparam int WO = 15;
   localparam int N  = 4;

   logic          clk;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N*WL-1:0] req_ar, req_ai, req_br, req_bi;
   logic          out_valid;
   logic          out_ready;
   logic [WO-1:0] out_cr, out_ci;
   logic [1:0]    out_id;

   int checks = 0;
   int errors = 0;

`ifdef CADD_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   cadd_arbiter #(.WL(WL), .WL_out(WO), .NREQ(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_ar    (req_ar),
      .req_ai    (req_ai),
      .req_br    (req_br),
      .req_bi    (req_bi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_cr    (out_cr),
      .out_ci    (out_ci),
      .out_id    (out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not end in time");
      $fatal(1);
   end

   // Standard operands: requester i gives cr = 100(i+1)+7, ci = 2(i+1).
   function automatic logic [WO-1:0] exp_cr(input int i);
      return WO'(100 * (i + 1) + 7);
   endfunction
   function automatic logic [WO-1:0] exp_ci(input int i);
      return WO'(2 * (i + 1));
   endfunction

   task automatic load_ops();
      for (int i = 0; i < N; i++) begin
         req_ar[i*WL +: WL] = 14'(100 * (i + 1));
         req_ai[i*WL +: WL] = 14'(-(i + 1));
         req_br[i*WL +: WL] = 14'd7;
         req_bi[i*WL +: WL] = 14'(3 * (i + 1));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 4'b1111; out_ready = 1'b1;
      load_ops();
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_comb: got %b want 0000", req_ready); end
      tick(); tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      checks++; if (out_cr !== 15'd0 || out_ci !== 15'd0) begin errors++; $display("FAIL reset_data: got %0h/%0h want 0/0", out_cr, out_ci); end
      checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", out_id); end
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
   endtask

   task automatic test_basic();
      rst_n = 1'b1; req_valid = 4'b0001;
      req_ar[0 +: WL] = 14'd100; req_ai[0 +: WL] = 14'(-5);
      req_br[0 +: WL] = 14'd27;  req_bi[0 +: WL] = 14'(-8);
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready: got %b want 0001", req_ready); end
      tick();
      req_valid = 4'b0000;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      checks++; if (out_cr !== 15'd127) begin errors++; $display("FAIL basic_cr: got %0h want %0h", out_cr, 15'd127); end
      checks++; if (out_ci !== 15'h7ff3) begin errors++; $display("FAIL basic_ci: got %0h want 7ff3", out_ci); end
      checks++; if (out_id !== 2'd0) begin errors++; $display("FAIL basic_id: got %0d want 0", out_id); end
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_empty: got %b want 0", out_valid); end
      load_ops();
   endtask

   task automatic test_extremes();
      req_ar[2*WL +: WL] = 14'h2000; req_br[2*WL +: WL] = 14'h2000;
      req_ai[2*WL +: WL] = 14'h1fff; req_bi[2*WL +: WL] = 14'h1fff;
      req_valid = 4'b0100;
      tick();
      req_valid = 4'b0000;
      checks++; if (out_cr !== 15'h4000) begin errors++; $display("FAIL ext_cr: got %0h want 4000", out_cr); end
      checks++; if (out_ci !== 15'h3ffe) begin errors++; $display("FAIL ext_ci: got %0h want 3ffe", out_ci); end
      checks++; if (out_id !== 2'd2 || out_valid !== 1'b1) begin errors++; $display("FAIL ext_id: got %0d/%b want 2/1", out_id, out_valid); end
      tick();
      load_ops();
   endtask

   task automatic test_arbitration();
      int e;
      rst_n = 1'b0; tick();
      rst_n = 1'b1; req_valid = 4'b1111; out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         e = RR ? (k % 4) : 0;
         #1;
         checks++; if (req_ready !== 4'(1 << e)) begin errors++; $display("FAIL arb_all_ready[%0d]: got %b want %b", k, req_ready, 4'(1 << e)); end
         tick();
         checks++; if (out_valid !== 1'b1 || out_id !== 2'(e) || out_cr !== exp_cr(e)) begin
            errors++; $display("FAIL arb_all_out[%0d]: got v%b id%0d cr%0h want v1 id%0d cr%0h", k, out_valid, out_id, out_cr, e, exp_cr(e));
         end
      end
      req_valid = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         e = RR ? ((k % 2 == 0) ? 1 : 3) : 1;
         tick();
         checks++; if (out_valid !== 1'b1 || out_id !== 2'(e) || out_ci !== exp_ci(e)) begin
            errors++; $display("FAIL arb_1010[%0d]: got v%b id%0d ci%0h want v1 id%0d ci%0h", k, out_valid, out_id, out_ci, e, exp_ci(e));
         end
      end
      req_valid = 4'b0000;
      tick();
   endtask

   task automatic test_stall();
      rst_n = 1'b0; tick();
      rst_n = 1'b1; req_valid = 4'b1111; out_ready = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL stall_first_ready: got %b want 0001", req_ready); end
      tick();
      for (int k = 0; k < 5; k++) begin
         checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0000", k, req_ready); end
         req_valid = (k % 2 == 0) ? 4'b0110 : 4'b1111;
         tick();
         checks++; if (out_valid !== 1'b1 || out_id !== 2'd0 || out_cr !== exp_cr(0) || out_ci !== exp_ci(0)) begin
            errors++; $display("FAIL stall_hold[%0d]: got v%b id%0d cr%0h ci%0h want v1 id0 cr%0h ci%0h", k, out_valid, out_id, out_cr, out_ci, exp_cr(0), exp_ci(0));
         end
      end
      req_valid = 4'b1111; out_ready = 1'b1;
      #1;
      checks++; if (req_ready !== (RR ? 4'b0010 : 4'b0001)) begin errors++; $display("FAIL stall_release_ready: got %b want %b", req_ready, RR ? 4'b0010 : 4'b0001); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_id !== (RR ? 2'd1 : 2'd0) || out_cr !== exp_cr(RR ? 1 : 0)) begin
         errors++; $display("FAIL stall_pop_reload: got v%b id%0d cr%0h want v1 id%0d", out_valid, out_id, out_cr, RR ? 1 : 0);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_held: got %b want 1", out_valid); end
      rst_n = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready_in_reset: got %b want 0000", req_ready); end
      tick();
      checks++; if (out_valid !== 1'b0 || out_id !== 2'd0 || out_cr !== 15'd0) begin
         errors++; $display("FAIL mid_reset_out: got v%b id%0d cr%0h want v0 id0 cr0", out_valid, out_id, out_cr);
      end
      rst_n = 1'b1; out_ready = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1 || out_id !== 2'd0) begin errors++; $display("FAIL mid_restart0: got v%b id%0d want v1 id0", out_valid, out_id); end
      tick();
      checks++; if (out_id !== (RR ? 2'd1 : 2'd0)) begin errors++; $display("FAIL mid_restart1: got id%0d want %0d", out_id, RR ? 1 : 0); end
      req_valid = 4'b0000;
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_drain: got %b want 0", out_valid); end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; out_ready = 1'b0;
      req_ar = '0; req_ai = '0; req_br = '0; req_bi = '0;
      test_reset();
      test_basic();
      test_extremes();
      test_arbitration();
      test_stall();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
